// File: rtl/ps2_rx_if.sv
// PS/2 receiver bus bundle.
// Keyboard lines in, received bytes and pulses out.
interface ps2_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] out;
  logic        byte_valid;
  logic        err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  out,
    input  byte_valid,
    input  err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output out,
    output byte_valid,
    output err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: sync, glitch filter,
// frame FSM with parity/stop check and timeout.
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic     clk,
  input  logic     rst,
  ps2_rx_if.slave  bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [FW-1:0] FLAST =
    FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TLIM =
    TW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic [1:0]    ck_sync;
  logic [1:0]    dt_sync;
  logic          ck_s;
  logic          dt_s;

  logic          filt;
  logic [FW-1:0] fcnt;
  logic          sample;

  logic [1:0]    state;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          tmo;
  logic          good;

  logic [15:0]   out_q;
  logic          bv_q;
  logic          err_q;

  assign ck_s = ck_sync[1];
  assign dt_s = dt_sync[1];

  // Two-flop synchronizers; idle bus level is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ck_sync <= 2'b11;
      dt_sync <= 2'b11;
    end else begin
      ck_sync <= {ck_sync[0], bus.ps2_clk};
      dt_sync <= {dt_sync[0], bus.ps2_data};
    end
  end

  // Filtered clock follows only a stable run.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (ck_s == filt) begin
      fcnt <= '0;
    end else if (fcnt == FLAST) begin
      filt <= ck_s;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // Falling edge of filtered clock, same
  // cycle as the filter output flips.
  assign sample = filt & ~ck_s &
                  (fcnt == FLAST);

  assign tmo  = (state != S_IDLE) &&
                (tcnt == TLIM);

  assign good = dt_s & (^{shreg, par});

  // Inactivity counter for partial frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state == S_IDLE || sample) begin
      tcnt <= '0;
    end else if (tcnt != TLIM) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Frame FSM; a sample event beats timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      bcnt  <= '0;
      shreg <= '0;
      par   <= 1'b0;
    end else if (sample) begin
      unique case (state)
        S_IDLE: begin
          if (!dt_s) begin
            state <= S_DATA;
            bcnt  <= '0;
          end
        end
        S_DATA: begin
          shreg <= {dt_s, shreg[7:1]};
          bcnt  <= bcnt + 1'b1;
          if (bcnt == 3'd7) state <= S_PAR;
        end
        S_PAR: begin
          par   <= dt_s;
          state <= S_STOP;
        end
        S_STOP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end else if (tmo) begin
      state <= S_IDLE;
    end
  end

  // Result register and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      bv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      bv_q  <= 1'b0;
      err_q <= 1'b0;
      if (sample && state == S_STOP) begin
        if (good) begin
          out_q <= {out_q[7:0], shreg};
          bv_q  <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.out        = out_q;
  assign bus.byte_valid = bv_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx.
// Table vectors, directed corners, random frames.
module tb_ps2_rx;

  localparam int FL  = 4;
  localparam int TO  = 200;
  localparam int H   = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ps2_rx_if bus ();

  ps2_rx #(
    .FILTER_LEN(FL),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int nv    = 0;
  int ne    = 0;
  int nboth = 0;

  logic [15:0] m_out = 16'h0000;

  typedef struct {
    logic [7:0]  b;
    logic        bad_par;
    logic        stop;
    logic [15:0] exp_out;
    int          exp_v;
    int          exp_e;
  } vec_t;

  vec_t vt [5];

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.byte_valid) nv++;
      if (bus.err) ne++;
      if (bus.byte_valid && bus.err) nboth++;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    cyc(H / 2);
    bus.ps2_clk = 1'b0;
    cyc(H);
    bus.ps2_clk = 1'b1;
    cyc(H / 2);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic bad_par,
                            input logic stop);
    logic p;
    p = (~^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(stop);
    bus.ps2_data = 1'b1;
    cyc(3 * H);
  endtask

  // Reference: odd ones over data+parity, stop=1.
  function automatic logic frame_good(
      input logic [7:0] b,
      input logic bad_par,
      input logic stop);
    logic p;
    int   ones;
    p    = (~^b) ^ bad_par;
    ones = $countones(b) + int'(p);
    return stop && (ones % 2 == 1);
  endfunction

  task automatic run_frame(input string nm,
                           input logic [7:0] b,
                           input logic bad_par,
                           input logic stop);
    int v0, e0, b0;
    logic g;
    v0 = nv; e0 = ne; b0 = nboth;
    g  = frame_good(b, bad_par, stop);
    send_frame(b, bad_par, stop);
    if (g) m_out = {m_out[7:0], b};
    chk({nm, " out"}, 32'(bus.out), 32'(m_out));
    chk({nm, " vld"}, 32'(nv - v0), g ? 1 : 0);
    chk({nm, " err"}, 32'(ne - e0), g ? 0 : 1);
    chk({nm, " both"}, 32'(nboth - b0), 0);
  endtask

  initial begin
    int v0, e0;
    logic [7:0] rb;
    int k;

    vt[0] = '{8'h1C, 1'b0, 1'b1, 16'h001C, 1, 0};
    vt[1] = '{8'hF0, 1'b0, 1'b1, 16'h1CF0, 1, 0};
    vt[2] = '{8'h1C, 1'b0, 1'b1, 16'hF01C, 1, 0};
    vt[3] = '{8'h1C, 1'b1, 1'b1, 16'hF01C, 0, 1};
    vt[4] = '{8'h1C, 1'b0, 1'b0, 16'hF01C, 0, 1};

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    cyc(5);
    @(negedge clk);
    chk("rst out", 32'(bus.out), 32'h0);
    chk("rst vld", 32'(bus.byte_valid), 32'h0);
    chk("rst err", 32'(bus.err), 32'h0);
    #1;
    rst = 1'b0;
    cyc(5);

    for (int i = 0; i < 5; i++) begin
      v0 = nv; e0 = ne;
      send_frame(vt[i].b, vt[i].bad_par, vt[i].stop);
      chk($sformatf("vec%0d out", i),
          32'(bus.out), 32'(vt[i].exp_out));
      chk($sformatf("vec%0d vld", i),
          32'(nv - v0), 32'(vt[i].exp_v));
      chk($sformatf("vec%0d err", i),
          32'(ne - e0), 32'(vt[i].exp_e));
    end
    m_out = 16'hF01C;
    chk("vec both", 32'(nboth), 32'h0);

    // Partial frame abandoned by timeout.
    v0 = nv; e0 = ne;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus.ps2_data = 1'b1;
    cyc(TO + 10);
    chk("tmo err", 32'(ne - e0), 32'h0);
    chk("tmo vld", 32'(nv - v0), 32'h0);
    chk("tmo out", 32'(bus.out), 32'(m_out));
    run_frame("tmo 5A", 8'h5A, 1'b0, 1'b1);
    chk("tmo low", 32'(bus.out[7:0]), 32'h5A);

    // Short low glitch on ps2_clk in idle.
    v0 = nv; e0 = ne;
    bus.ps2_clk = 1'b0;
    cyc(FL - 2);
    bus.ps2_clk = 1'b1;
    cyc(20);
    chk("glitch err", 32'(ne - e0), 32'h0);
    run_frame("glitch 23", 8'h23, 1'b0, 1'b1);
    chk("glitch low", 32'(bus.out[7:0]), 32'h23);

    // Reset in the middle of a frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    m_out = 16'h0000;
    v0 = nv; e0 = ne;
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("mid-rst out", 32'(bus.out), 32'h001C);
    chk("mid-rst vld", 32'(nv - v0), 32'h1);
    chk("mid-rst err", 32'(ne - e0), 32'h0);
    m_out = 16'h001C;

    // Random frames against the model.
    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom);
      k  = int'($urandom_range(0, 3));
      run_frame($sformatf("rnd%0d", i), rb,
                k == 0, k != 1);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
